// File: rtl/wat_access_ctrl_pkg.sv
// Shared definitions for the Write Address Table access controller.
// WAT geometry (address width, entry width, table depth) and the
// controller FSM state type.
package wat_access_ctrl_pkg;

  localparam int unsigned WAT_ADDR_W = 14;
  localparam int unsigned WAT_DATA_W = 128;
  localparam int unsigned WAT_DEPTH  = 16384;

  typedef enum logic {
    WAT_CTRL_INIT = 1'b0,
    WAT_CTRL_RUN  = 1'b1
  } wat_ctrl_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// N-way round-robin arbiter.
//   clk, rst_n  : clock, synchronous active-low reset (pointer -> 0)
//   i_valid     : per-requester request
//   i_update    : advance pointer past the current grant (if any)
//   o_grant     : one-hot grant, lowest index >= pointer (wrapping) with valid set
module rr_arbiter #(
  parameter int unsigned N = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] i_valid,
  input  logic         i_update,
  output logic [N-1:0] o_grant
);

  localparam int unsigned PTR_W = (N > 1) ? $clog2(N) : 1;

  logic [PTR_W-1:0] r_ptr;
  logic [PTR_W-1:0] w_ptr_nxt;

  always_comb begin
    logic        found;
    int unsigned idx;
    found     = 1'b0;
    idx       = 0;
    o_grant   = '0;
    w_ptr_nxt = r_ptr;
    for (int unsigned i = 0; i < N; i++) begin
      idx = (32'(r_ptr) + i) % N;
      for (int unsigned j = 0; j < N; j++) begin
        if (!found && (j == idx) && i_valid[j]) begin
          found      = 1'b1;
          o_grant[j] = 1'b1;
          w_ptr_nxt  = PTR_W'((j + 1) % N);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_ptr <= '0;
    end else if (i_update) begin
      r_ptr <= w_ptr_nxt;
    end
  end

endmodule

// File: rtl/wat_access_ctrl.sv
// WAT BRAM sequencer/arbiter: zero-fill sweep after reset or clear,
// single CEU write port, round-robin lookup port with a 2-cycle pipeline
// and same-cycle read/write collision bypass.
//   i_clear                         : re-zero request (honoured in RUN only)
//   o_init_done                     : table usable
//   i_wr_valid/iv_wr_addr/iv_wr_data/o_wr_ready : CEU write
//   iv_rd_valid/iv_rd_addr/ov_rd_ready           : lookup requests / one-hot grant
//   ov_rsp_valid/ov_rsp_data                     : lookup response (latency 2)
//   o_wat_wr_en/ov_wat_addra/ov_wat_wr_data      : BRAM port A
//   ov_wat_addrb/iv_wat_rd_data                  : BRAM port B (1-cycle latency)
module wat_access_ctrl
  import wat_access_ctrl_pkg::*;
#(
  parameter int unsigned NUM_RD = 2,
  parameter int unsigned ADDR_W = WAT_ADDR_W,
  parameter int unsigned DATA_W = WAT_DATA_W,
  parameter int unsigned DEPTH  = WAT_DEPTH
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_clear,
  output logic                     o_init_done,
  input  logic                     i_wr_valid,
  input  logic [ADDR_W-1:0]        iv_wr_addr,
  input  logic [DATA_W-1:0]        iv_wr_data,
  output logic                     o_wr_ready,
  input  logic [NUM_RD-1:0]        iv_rd_valid,
  input  logic [NUM_RD*ADDR_W-1:0] iv_rd_addr,
  output logic [NUM_RD-1:0]        ov_rd_ready,
  output logic [NUM_RD-1:0]        ov_rsp_valid,
  output logic [DATA_W-1:0]        ov_rsp_data,
  output logic                     o_wat_wr_en,
  output logic [ADDR_W-1:0]        ov_wat_addra,
  output logic [DATA_W-1:0]        ov_wat_wr_data,
  output logic [ADDR_W-1:0]        ov_wat_addrb,
  input  logic [DATA_W-1:0]        iv_wat_rd_data
);

  localparam logic [ADDR_W-1:0] LP_LAST = ADDR_W'(DEPTH - 1);

  wat_ctrl_state_e     r_state, w_state_nxt;
  logic [ADDR_W-1:0]   r_cnt, w_cnt_nxt;
  logic                r_init_done;
  logic                w_clr;
  logic                w_wr_acc;

  logic                r_wa_en;
  logic [ADDR_W-1:0]   r_wa_addr;
  logic [DATA_W-1:0]   r_wa_data;

  logic [NUM_RD-1:0]   w_rd_req;
  logic [NUM_RD-1:0]   w_grant;
  logic [ADDR_W-1:0]   w_gnt_addr;
  logic [NUM_RD-1:0]   r_s1_vld;
  logic [ADDR_W-1:0]   r_rdb_addr;
  logic [NUM_RD-1:0]   r_rsp_vld;
  logic                r_coll;
  logic [DATA_W-1:0]   r_coll_data;

  // Port A is fully registered, so the usable flag lags the FSM by one
  // cycle: it rises only once the last sweep write is on the BRAM port.
  assign w_clr    = i_clear & r_init_done;
  assign w_wr_acc = i_wr_valid & r_init_done;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= WAT_CTRL_INIT;
      r_cnt       <= '0;
      r_init_done <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_init_done <= (r_state == WAT_CTRL_RUN) & ~w_clr;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      WAT_CTRL_INIT: begin
        w_cnt_nxt = r_cnt + 1'b1;
        if (r_cnt == LP_LAST) begin
          w_state_nxt = WAT_CTRL_RUN;
          w_cnt_nxt   = '0;
        end
      end
      WAT_CTRL_RUN: begin
        if (w_clr) begin
          w_state_nxt = WAT_CTRL_INIT;
        end
      end
      default: w_state_nxt = WAT_CTRL_INIT;
    endcase
  end

  // A write accepted alongside a clear is registered while still in RUN,
  // so it occupies port A before the first sweep write.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wa_en   <= 1'b0;
      r_wa_addr <= '0;
      r_wa_data <= '0;
    end else if (r_state == WAT_CTRL_INIT) begin
      r_wa_en   <= 1'b1;
      r_wa_addr <= r_cnt;
      r_wa_data <= '0;
    end else if (w_wr_acc) begin
      r_wa_en   <= 1'b1;
      r_wa_addr <= iv_wr_addr;
      r_wa_data <= iv_wr_data;
    end else begin
      r_wa_en   <= 1'b0;
    end
  end

  assign w_rd_req = iv_rd_valid & {NUM_RD{r_init_done}};

  rr_arbiter #(
    .N (NUM_RD)
  ) u_rr_arbiter (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_valid  (w_rd_req),
    .i_update (r_init_done),
    .o_grant  (w_grant)
  );

  always_comb begin
    w_gnt_addr = '0;
    for (int unsigned i = 0; i < NUM_RD; i++) begin
      if (w_grant[i]) begin
        w_gnt_addr = iv_rd_addr[i*ADDR_W +: ADDR_W];
      end
    end
  end

  // Stage 1 drives addrb; stage 2 presents BRAM dout, or the port-A data
  // if port A wrote the same address in the addrb cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_s1_vld    <= '0;
      r_rdb_addr  <= '0;
      r_rsp_vld   <= '0;
      r_coll      <= 1'b0;
      r_coll_data <= '0;
    end else begin
      r_s1_vld    <= w_grant;
      if (|w_grant) begin
        r_rdb_addr <= w_gnt_addr;
      end
      r_rsp_vld   <= r_s1_vld;
      r_coll      <= r_wa_en & (r_wa_addr == r_rdb_addr);
      r_coll_data <= r_wa_data;
    end
  end

  assign o_init_done    = r_init_done;
  assign o_wr_ready     = r_init_done;
  assign ov_rd_ready    = w_grant;
  assign ov_rsp_valid   = r_rsp_vld;
  assign ov_rsp_data    = (|r_rsp_vld) ? (r_coll ? r_coll_data : iv_wat_rd_data) : '0;
  assign o_wat_wr_en    = r_wa_en;
  assign ov_wat_addra   = r_wa_addr;
  assign ov_wat_wr_data = r_wa_data;
  assign ov_wat_addrb   = r_rdb_addr;

endmodule

// File: tb/tb_wat_access_ctrl.sv
module tb_wat_access_ctrl;

  localparam int unsigned NUM_RD = 2;
  localparam int unsigned ADDR_W = 14;
  localparam int unsigned DATA_W = 128;
  localparam int unsigned DEPTH  = 16;

  localparam logic [127:0] GARB = {4{32'hDEAD_BEEF}};
  localparam logic [127:0] A5   = {16{8'hA5}};
  localparam logic [127:0] B1   = {8{16'hB1B1}};
  localparam logic [127:0] B2   = {8{16'hB2B2}};
  localparam logic [127:0] D1   = {4{32'hD1D1_0001}};
  localparam logic [127:0] D2   = {4{32'hD2D2_0002}};
  localparam logic [127:0] PAT  = {4{32'h5A5A_F00D}};

  logic                     clk = 1'b0;
  logic                     rst_n;
  logic                     i_clear;
  logic                     o_init_done;
  logic                     i_wr_valid;
  logic [ADDR_W-1:0]        iv_wr_addr;
  logic [DATA_W-1:0]        iv_wr_data;
  logic                     o_wr_ready;
  logic [NUM_RD-1:0]        iv_rd_valid;
  logic [NUM_RD*ADDR_W-1:0] iv_rd_addr;
  logic [NUM_RD-1:0]        ov_rd_ready;
  logic [NUM_RD-1:0]        ov_rsp_valid;
  logic [DATA_W-1:0]        ov_rsp_data;
  logic                     o_wat_wr_en;
  logic [ADDR_W-1:0]        ov_wat_addra;
  logic [DATA_W-1:0]        ov_wat_wr_data;
  logic [ADDR_W-1:0]        ov_wat_addrb;
  logic [DATA_W-1:0]        iv_wat_rd_data;

  always #5 clk = ~clk;

  wat_access_ctrl #(
    .NUM_RD (NUM_RD),
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .i_clear        (i_clear),
    .o_init_done    (o_init_done),
    .i_wr_valid     (i_wr_valid),
    .iv_wr_addr     (iv_wr_addr),
    .iv_wr_data     (iv_wr_data),
    .o_wr_ready     (o_wr_ready),
    .iv_rd_valid    (iv_rd_valid),
    .iv_rd_addr     (iv_rd_addr),
    .ov_rd_ready    (ov_rd_ready),
    .ov_rsp_valid   (ov_rsp_valid),
    .ov_rsp_data    (ov_rsp_data),
    .o_wat_wr_en    (o_wat_wr_en),
    .ov_wat_addra   (ov_wat_addra),
    .ov_wat_wr_data (ov_wat_wr_data),
    .ov_wat_addrb   (ov_wat_addrb),
    .iv_wat_rd_data (iv_wat_rd_data)
  );

  // BRAM model: 1-cycle read latency, garbage on same-cycle address clash.
  logic [127:0] mem [0:16383];
  initial for (int i = 0; i < 16384; i++) mem[i] = PAT;
  always @(posedge clk) begin
    if (o_wat_wr_en && ov_wat_addra == ov_wat_addrb) iv_wat_rd_data <= GARB;
    else iv_wat_rd_data <= mem[ov_wat_addrb];
    if (o_wat_wr_en) mem[ov_wat_addra] <= ov_wat_wr_data;
  end

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic         wr_v;
    logic [13:0]  wr_a;
    logic [127:0] wr_d;
    logic [1:0]   rd_v;
    logic [13:0]  a0;
    logic [13:0]  a1;
    logic [1:0]   e_rdy;
    logic [1:0]   e_rsp;
    logic [127:0] e_dat;
    logic         e_wen;
    logic [13:0]  e_wa;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic wv, input logic [13:0] wa, input logic [127:0] wd,
                     input logic [1:0] rv, input logic [13:0] a0, input logic [13:0] a1,
                     input logic [1:0] er, input logic [1:0] es, input logic [127:0] ed,
                     input logic ew, input logic [13:0] ewa);
    vec_t v;
    v.wr_v = wv; v.wr_a = wa; v.wr_d = wd; v.rd_v = rv; v.a0 = a0; v.a1 = a1;
    v.e_rdy = er; v.e_rsp = es; v.e_dat = ed; v.e_wen = ew; v.e_wa = ewa;
    tbl.push_back(v);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    i_clear = 0; i_wr_valid = 0; iv_wr_addr = '0; iv_wr_data = '0;
    iv_rd_valid = '0; iv_rd_addr = '0;
  endtask

  initial begin
    int  n_wr;
    int  lo;
    bit  done;
    bit  prev_en;

    //             wv wa      wd  rv     a0      a1     rdy    rsp    dat wen wa
    add(1, 14'h012, A5, 2'b00, 14'h0,   14'h0,   2'b00, 2'b00, 0,  0, 14'h0);   // v0
    add(0, 14'h0,   0,  2'b00, 14'h0,   14'h0,   2'b00, 2'b00, 0,  1, 14'h012); // v1
    add(0, 14'h0,   0,  2'b01, 14'h012, 14'h0,   2'b01, 2'b00, 0,  0, 14'h0);   // v2
    add(0, 14'h0,   0,  2'b00, 14'h0,   14'h0,   2'b00, 2'b00, 0,  0, 14'h0);   // v3
    add(0, 14'h0,   0,  2'b00, 14'h0,   14'h0,   2'b00, 2'b01, A5, 0, 14'h0);   // v4
    add(1, 14'h001, B1, 2'b00, 14'h0,   14'h0,   2'b00, 2'b00, 0,  0, 14'h0);   // v5
    add(1, 14'h002, B2, 2'b00, 14'h0,   14'h0,   2'b00, 2'b00, 0,  1, 14'h001); // v6
    add(0, 14'h0,   0,  2'b11, 14'h001, 14'h002, 2'b10, 2'b00, 0,  1, 14'h002); // v7
    add(0, 14'h0,   0,  2'b11, 14'h001, 14'h002, 2'b01, 2'b00, 0,  0, 14'h0);   // v8
    add(0, 14'h0,   0,  2'b11, 14'h001, 14'h002, 2'b10, 2'b10, B2, 0, 14'h0);   // v9
    add(0, 14'h0,   0,  2'b11, 14'h001, 14'h002, 2'b01, 2'b01, B1, 0, 14'h0);   // v10
    add(0, 14'h0,   0,  2'b00, 14'h0,   14'h0,   2'b00, 2'b10, B2, 0, 14'h0);   // v11
    add(0, 14'h0,   0,  2'b00, 14'h0,   14'h0,   2'b00, 2'b01, B1, 0, 14'h0);   // v12
    add(0, 14'h0,   0,  2'b00, 14'h0,   14'h0,   2'b00, 2'b00, 0,  0, 14'h0);   // v13
    add(1, 14'h100, D1, 2'b01, 14'h100, 14'h0,   2'b01, 2'b00, 0,  0, 14'h0);   // v14
    add(0, 14'h0,   0,  2'b00, 14'h0,   14'h0,   2'b00, 2'b00, 0,  1, 14'h100); // v15
    add(0, 14'h0,   0,  2'b00, 14'h0,   14'h0,   2'b00, 2'b01, D1, 0, 14'h0);   // v16
    add(0, 14'h0,   0,  2'b10, 14'h0,   14'h012, 2'b10, 2'b00, 0,  0, 14'h0);   // v17
    add(1, 14'h012, D2, 2'b00, 14'h0,   14'h0,   2'b00, 2'b00, 0,  0, 14'h0);   // v18
    add(0, 14'h0,   0,  2'b00, 14'h0,   14'h0,   2'b00, 2'b10, A5, 1, 14'h012); // v19
    add(0, 14'h0,   0,  2'b01, 14'h012, 14'h0,   2'b01, 2'b00, 0,  0, 14'h0);   // v20
    add(0, 14'h0,   0,  2'b00, 14'h0,   14'h0,   2'b00, 2'b00, 0,  0, 14'h0);   // v21
    add(0, 14'h0,   0,  2'b00, 14'h0,   14'h0,   2'b00, 2'b01, D2, 0, 14'h0);   // v22
    add(0, 14'h0,   0,  2'b01, 14'h005, 14'h0,   2'b01, 2'b00, 0,  0, 14'h0);   // v23
    add(0, 14'h0,   0,  2'b00, 14'h0,   14'h0,   2'b00, 2'b00, 0,  0, 14'h0);   // v24
    add(0, 14'h0,   0,  2'b00, 14'h0,   14'h0,   2'b00, 2'b01, 0,  0, 14'h0);   // v25

    // ---- reset and init sweep (readies must stay 0 with requests pending)
    idle_inputs();
    rst_n = 0;
    iv_rd_valid = 2'b11;
    iv_rd_addr  = {14'h002, 14'h001};
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_wr_en", o_wat_wr_en, 0);
    chk("rst_init_done", o_init_done, 0);
    chk("rst_wr_ready", o_wr_ready, 0);
    chk("rst_rd_ready", ov_rd_ready, 0);
    chk("rst_rsp_valid", ov_rsp_valid, 0);
    chk("rst_rsp_data", ov_rsp_data, 0);
    chk("rst_addra", ov_wat_addra, 0);
    chk("rst_addrb", ov_wat_addrb, 0);
    tick();
    rst_n = 1;

    n_wr = 0; done = 0; prev_en = 0;
    for (int c = 0; c < 100 && !done; c++) begin
      @(negedge clk);
      if (o_init_done) begin
        done = 1;
        chk("init_sweep_len", n_wr, DEPTH);
        chk("init_done_after_last_wr", prev_en, 1);
        chk("init_first_grant", ov_rd_ready, 2'b01);
        chk("init_wr_ready", o_wr_ready, 1);
        iv_rd_valid = 2'b00;
      end else begin
        if (o_wat_wr_en) begin
          chk("init_addra", ov_wat_addra, n_wr);
          chk("init_wdata", ov_wat_wr_data, 0);
          n_wr++;
        end
        chk("init_rd_ready", ov_rd_ready, 0);
        chk("init_wr_ready", o_wr_ready, 0);
        prev_en = o_wat_wr_en;
        @(posedge clk);
      end
    end
    if (!done) chk("init_timeout", 0, 1);
    tick();

    // ---- table-driven RUN vectors
    foreach (tbl[k]) begin
      i_wr_valid  = tbl[k].wr_v;
      iv_wr_addr  = tbl[k].wr_a;
      iv_wr_data  = tbl[k].wr_d;
      iv_rd_valid = tbl[k].rd_v;
      iv_rd_addr  = {tbl[k].a1, tbl[k].a0};
      @(negedge clk);
      chk($sformatf("v%0d_rd_ready", k), ov_rd_ready, tbl[k].e_rdy);
      chk($sformatf("v%0d_rsp_valid", k), ov_rsp_valid, tbl[k].e_rsp);
      chk($sformatf("v%0d_rsp_data", k), ov_rsp_data, tbl[k].e_dat);
      chk($sformatf("v%0d_wr_en", k), o_wat_wr_en, tbl[k].e_wen);
      if (tbl[k].e_wen) chk($sformatf("v%0d_addra", k), ov_wat_addra, tbl[k].e_wa);
      tick();
    end

    // ---- clear with a read in flight and a same-cycle write
    idle_inputs();
    i_clear = 1; i_wr_valid = 1; iv_wr_addr = 14'h003; iv_wr_data = D1;
    iv_rd_valid = 2'b10; iv_rd_addr = {14'h002, 14'h000};
    @(negedge clk);
    chk("clr_grant", ov_rd_ready, 2'b10);
    chk("clr_wr_ready", o_wr_ready, 1);
    tick();
    idle_inputs();
    iv_rd_valid = 2'b11; iv_rd_addr = {14'h003, 14'h001};
    @(negedge clk);
    chk("clr_init_done_drop", o_init_done, 0);
    chk("clr_wr_ready_drop", o_wr_ready, 0);
    chk("clr_rd_ready_drop", ov_rd_ready, 0);
    chk("clr_pending_wr_en", o_wat_wr_en, 1);
    chk("clr_pending_addra", ov_wat_addra, 14'h003);
    chk("clr_pending_data", ov_wat_wr_data, D1);
    tick();
    @(negedge clk);
    chk("clr_inflight_valid", ov_rsp_valid, 2'b10);
    chk("clr_inflight_data", ov_rsp_data, B2);
    n_wr = 0; lo = 2; done = 0;
    if (o_wat_wr_en) begin
      chk("clr_sweep_addra", ov_wat_addra, 0);
      n_wr = 1;
    end
    for (int c = 0; c < 100 && !done; c++) begin
      tick();
      @(negedge clk);
      if (o_init_done) begin
        done = 1;
        chk("clr_sweep_len", n_wr, DEPTH);
        chk("clr_low_ge_depth", lo >= DEPTH, 1);
        chk("clr_first_grant", ov_rd_ready, 2'b01);
        iv_rd_valid = 2'b00;
      end else begin
        lo++;
        if (o_wat_wr_en) begin
          chk("clr_sweep_addra", ov_wat_addra, n_wr);
          n_wr++;
        end
        chk("clr_rd_ready", ov_rd_ready, 0);
      end
    end
    if (!done) chk("clr_timeout", 0, 1);
    tick();
    iv_rd_valid = 2'b10; iv_rd_addr = {14'h003, 14'h000};
    @(negedge clk);
    chk("post_clr_grant1", ov_rd_ready, 2'b10);
    tick();
    iv_rd_valid = 2'b01; iv_rd_addr = {14'h000, 14'h001};
    @(negedge clk);
    chk("post_clr_grant0", ov_rd_ready, 2'b01);
    tick();
    iv_rd_valid = 2'b00;
    @(negedge clk);
    chk("post_clr_rsp1_valid", ov_rsp_valid, 2'b10);
    chk("post_clr_rsp1_data", ov_rsp_data, 0);
    tick();
    @(negedge clk);
    chk("post_clr_rsp0_valid", ov_rsp_valid, 2'b01);
    chk("post_clr_rsp0_data", ov_rsp_data, 0);
    tick();

    // ---- reset while a read is in the pipeline
    iv_rd_valid = 2'b01; iv_rd_addr = {14'h000, 14'h001};
    @(negedge clk);
    chk("rstp_grant", ov_rd_ready, 2'b01);
    tick();
    iv_rd_valid = 2'b00;
    rst_n = 0;
    @(negedge clk);
    chk("rstp_addrb", ov_wat_addrb, 14'h001);
    tick();
    rst_n = 1;
    @(negedge clk);
    chk("rstp_rsp_valid0", ov_rsp_valid, 0);
    chk("rstp_wr_en0", o_wat_wr_en, 0);
    chk("rstp_init_done", o_init_done, 0);
    tick();
    @(negedge clk);
    chk("rstp_rsp_valid1", ov_rsp_valid, 0);
    chk("rstp_sweep_en", o_wat_wr_en, 1);
    chk("rstp_sweep_addra", ov_wat_addra, 0);
    for (int c = 0; c < 3; c++) begin
      tick();
      @(negedge clk);
      chk("rstp_rsp_valid_later", ov_rsp_valid, 0);
    end

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

endmodule

// File: doc/wat_access_ctrl.md
Name: wat_access_ctrl

Overview:
Sequencer and arbiter in front of the Write Address Table (WAT) BRAM, 128b x 16384 simple-dual-port. It zero-fills the table after reset or on a clear request. It accepts table updates from the CEU configuration path on the single write port, and round-robins NUM_RD lookup requesters (RequesterEngine, ResponderEngine) onto the single read port. Same-cycle read/write address collisions are resolved inside this block, so the BRAM wrapper needs no bypass logic.

Parameters:
NUM_RD, 2, number of read requesters
ADDR_W, 14, table address width
DATA_W, 128, entry width
DEPTH, 16384, entries zeroed by the init sweep (must be ≤ 2^ADDR_W)

Ports:
clk  in  1  sole clock
rst_n  in  1  reset, synchronous, active-low
i_clear  in  1  one-cycle pulse: re-zero whole table
o_init_done  out  1  high when table is usable
i_wr_valid  in  1  CEU write request
iv_wr_addr  in  ADDR_W  write index
iv_wr_data  in  DATA_W  write entry
o_wr_ready  out  1  write accepted when valid&ready
iv_rd_valid  in  NUM_RD  per-requester lookup request
iv_rd_addr  in  NUM_RD*ADDR_W  packed lookup indices, requester i at [i*ADDR_W +: ADDR_W]
ov_rd_ready  out  NUM_RD  one-hot grant
ov_rsp_valid  out  NUM_RD  one-hot response strobe, no backpressure
ov_rsp_data  out  DATA_W  lookup result, shared by all requesters
o_wat_wr_en  out  1  BRAM port A write enable
ov_wat_addra  out  ADDR_W  BRAM port A address
ov_wat_wr_data  out  DATA_W  BRAM port A data
ov_wat_addrb  out  ADDR_W  BRAM port B address
iv_wat_rd_data  in  DATA_W  BRAM port B doutb (1-cycle read latency)

Behaviour:
- Reset (rst_n low at clk edge): all outputs 0, state=INIT, sweep counter=0, RR pointer=0, pipeline valids cleared. Any in-flight read is dropped and its response is never issued.
- FSM INIT:
  - o_wat_wr_en=1, addra=counter, data=0.
  - Counter +1 per cycle; o_wr_ready=0, ov_rd_ready=0.
  - After the write at DEPTH-1: go to RUN, counter cleared, o_init_done=1 the next cycle.
  - Sweep length is exactly DEPTH cycles.
- FSM RUN:
  - o_wr_ready=1 always.
  - Accepted write is registered and appears on port A the next cycle (o_wat_wr_en=1 for exactly one cycle per accepted write).
  - i_clear in RUN: go to INIT next cycle, o_init_done drops next cycle, readies drop next cycle. Reads already granted complete normally. A write accepted in the same cycle as i_clear still lands before the sweep starts.
  - i_clear during INIT is ignored.
- Read arbitration:
  - Round-robin starting at pointer p; grant is the lowest index ≥ p (wrapping) with valid set.
  - ov_rd_ready is combinational from valids and is 0 outside RUN.
  - After a grant to k, p = (k+1) mod NUM_RD; p is unchanged when nothing is granted.
  - One grant per cycle.
- Read pipeline: grant in cycle T → addrb registered, driven in T+1 → ov_rsp_valid[k] and ov_rsp_data in T+2 (latency 2). Throughput is 1 lookup per cycle.
- Collision:
  - If port A writes address X in cycle T+1 while addrb=X in T+1, the port-A data is captured and returned in T+2 instead of iv_wat_rd_data.
  - A read granted in the same cycle as a write acceptance to the same address therefore returns the new data.
  - A read whose addrb cycle precedes the write returns the old data.
- No ordering or buffering beyond the 2-stage pipeline. Requesters must sink responses unconditionally.
- ov_rsp_data=0 when no response is valid.

Decomposition:
- Shared package (chip_include_rdma.vh): WAT_ADDR_W=14, WAT_DATA_W=128, WAT_DEPTH=16384, FSM state encodings WAT_CTRL_INIT/WAT_CTRL_RUN.
- One sub-module: rr_arbiter (NUM_RD-wide round-robin, valid in / one-hot grant out, pointer update input). It is reusable elsewhere in the RDMA engine.
- The rest stays flat: FSM, sweep counter, write register, read pipeline, collision compare.

Test Plan:
- Reset then idle, DEPTH shrunk to 16 → o_wat_wr_en high 16 consecutive cycles, addra 0..15, data 0. o_init_done rises in cycle 17 (1-based from the first sweep write); all readies 0 until then.
- Write addr 0x0012 data 0xA5..A5, then a read of 0x0012 from requester 0 two cycles later → port A write one cycle after acceptance. ov_rsp_valid=01 two cycles after grant with data 0xA5..A5.
- Both requesters valid continuously, addrs 0x0001/0x0002 → grants alternate 01,10,01,10. Responses alternate with matching data every cycle, full throughput.
- Write 0x0100←D1 accepted in the same cycle as read 0x0100 is granted, BRAM model returning garbage on collision → response data = D1.
- i_clear while requester 1 has a read in flight → that response still delivered. o_init_done low for DEPTH cycles, readies 0. A subsequent read of a previously written address returns 0.
- rst_n low one cycle while a read is in the pipeline → no ov_rsp_valid afterward, FSM restarts at INIT with addra=0.
